// File: rtl/bitonic_pkg.sv
// rtl/bitonic_pkg.sv - shared constants, state enum and stage pair tables for the bitonic sorter
package bitonic_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int N          = 8;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SORT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Per stage: four (i,j) pairs; up=1 puts the minimum at i and the maximum at j.
    typedef struct packed {
        logic [3:0][2:0] i;
        logic [3:0][2:0] j;
        logic [3:0]      up;
    } stage_t;

    function automatic stage_t stage_tbl(input logic [2:0] stage);
        stage_t s;
        case (stage)
            3'd0: begin s.i = {3'd6, 3'd4, 3'd2, 3'd0}; s.j = {3'd7, 3'd5, 3'd3, 3'd1}; s.up = 4'b0101; end
            3'd1: begin s.i = {3'd5, 3'd4, 3'd1, 3'd0}; s.j = {3'd7, 3'd6, 3'd3, 3'd2}; s.up = 4'b0011; end
            3'd2: begin s.i = {3'd6, 3'd4, 3'd2, 3'd0}; s.j = {3'd7, 3'd5, 3'd3, 3'd1}; s.up = 4'b0011; end
            3'd3: begin s.i = {3'd3, 3'd2, 3'd1, 3'd0}; s.j = {3'd7, 3'd6, 3'd5, 3'd4}; s.up = 4'b1111; end
            3'd4: begin s.i = {3'd5, 3'd4, 3'd1, 3'd0}; s.j = {3'd7, 3'd6, 3'd3, 3'd2}; s.up = 4'b1111; end
            default: begin s.i = {3'd6, 3'd4, 3'd2, 3'd0}; s.j = {3'd7, 3'd5, 3'd3, 3'd1}; s.up = 4'b1111; end
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bitonic_cas.sv
// rtl/bitonic_cas.sv - one combinational compare-and-swap (dir=1: lo=min, hi=max)
module bitonic_cas #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         dir,
    output logic [W-1:0] lo,
    output logic [W-1:0] hi
);

    logic swap;

    // Equal operands never swap, so ties keep their slots.
    assign swap = dir ? (a > b) : (a < b);
    assign lo   = swap ? b : a;
    assign hi   = swap ? a : b;

endmodule

// File: rtl/bitonic_stream_sorter.sv
// rtl/bitonic_stream_sorter.sv - 8-entry sequential bitonic sorter, descending unless BITONIC_ASCEND_EN
module bitonic_stream_sorter
    import bitonic_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              busy
);

    state_t            state_q, state_d;
    logic [2:0]        cnt_q;
    logic [2:0]        stage_q;
    logic [DATA_W-1:0] e      [N];
    logic [DATA_W-1:0] e_next [N];
    stage_t            st;
    logic [3:0]        dir;
    logic [DATA_W-1:0] cas_a  [4];
    logic [DATA_W-1:0] cas_b  [4];
    logic [DATA_W-1:0] cas_lo [4];
    logic [DATA_W-1:0] cas_hi [4];

    assign st = stage_tbl(stage_q);
`ifdef BITONIC_ASCEND_EN
    assign dir = st.up;
`else
    assign dir = ~st.up;
`endif

    for (genvar k = 0; k < 4; k++) begin : g_cas
        assign cas_a[k] = e[st.i[k]];
        assign cas_b[k] = e[st.j[k]];
        bitonic_cas #(.W(DATA_W)) u_cas (
            .a   (cas_a[k]),
            .b   (cas_b[k]),
            .dir (dir[k]),
            .lo  (cas_lo[k]),
            .hi  (cas_hi[k])
        );
    end

    // Pairs within one stage are disjoint, so the write-back order does not matter.
    always_comb begin
        e_next = e;
        for (int k = 0; k < 4; k++) begin
            e_next[st.i[k]] = cas_lo[k];
            e_next[st.j[k]] = cas_hi[k];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD:    if (in_valid && cnt_q == 3'd7) state_d = SORT;
            SORT:    if (stage_q == 3'd5) state_d = DRAIN;
            DRAIN:   if (out_ready && cnt_q == 3'd7) state_d = LOAD;
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= LOAD;
            cnt_q   <= 3'd0;
            stage_q <= 3'd0;
            for (int k = 0; k < N; k++) e[k] <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                LOAD: begin
                    stage_q <= 3'd0;
                    if (in_valid) begin
                        e[cnt_q] <= in_data;
                        cnt_q    <= cnt_q + 3'd1;
                    end
                end
                SORT: begin
                    e       <= e_next;
                    cnt_q   <= 3'd0;
                    stage_q <= (stage_q == 3'd5) ? 3'd0 : stage_q + 3'd1;
                end
                DRAIN: begin
                    if (out_ready) cnt_q <= cnt_q + 3'd1;
                end
                default: begin
                    cnt_q   <= 3'd0;
                    stage_q <= 3'd0;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == LOAD);
    assign out_valid = (state_q == DRAIN);
    assign busy      = (state_q != LOAD);
    assign out_data  = e[cnt_q];

endmodule

// File: tb/tb_bitonic_stream_sorter.sv
// tb/tb_bitonic_stream_sorter.sv - directed self-checking bench for bitonic_stream_sorter
module tb_bitonic_stream_sorter;

    typedef logic [7:0] frame_t [8];

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic       busy;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int t_first;
    int t_a;
    int t_b;

    frame_t fin, fexp;

    bitonic_stream_sorter #(.DATA_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents 8 beats back to back; leaves in_valid/in_data as given afterwards.
    task automatic load_frame(input frame_t d, input logic v_after, input logic [7:0] d_after);
        t_first = cyc;
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1;
            in_data  = d[k];
            check("load_in_ready", int'(in_ready), 1);
            step();
        end
        in_valid = v_after;
        in_data  = d_after;
    endtask

    task automatic wait_sorted();
        int n = 0;
        check("sort_in_ready", int'(in_ready), 0);
        check("sort_busy", int'(busy), 1);
        while (out_valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check("sort_latency_edges", n, 6);
    endtask

    task automatic drain(input frame_t exp, input int stall_at);
        for (int k = 0; k < 8; k++) begin
            logic [7:0] x;
`ifdef BITONIC_ASCEND_EN
            x = exp[7-k];
`else
            x = exp[k];
`endif
            if (k == stall_at) begin
                out_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    check("stall_out_valid", int'(out_valid), 1);
                    check("stall_out_data", int'(out_data), int'(x));
                    step();
                end
            end
            out_ready = 1'b1;
            check("drain_out_valid", int'(out_valid), 1);
            check("drain_in_ready", int'(in_ready), 0);
            check($sformatf("drain_data_%0d", k), int'(out_data), int'(x));
            step();
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'd0;
        out_ready = 1'b1;
        step();
        step();
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_out_data", int'(out_data), 0);
        rst_n = 1'b1;
        step();
        check("idle_in_ready", int'(in_ready), 1);

        // Mixed values with ties; 99 held on the input during SORT/DRAIN with a mid-drain stall
        fin  = '{8'd3, 8'd7, 8'd1, 8'd0, 8'd255, 8'd8, 8'd8, 8'd2};
        fexp = '{8'd255, 8'd8, 8'd8, 8'd7, 8'd3, 8'd2, 8'd1, 8'd0};
        load_frame(fin, 1'b1, 8'd99);
        wait_sorted();
        drain(fexp, 3);
        in_valid = 1'b0;
        step();
        check("after_drain_busy", int'(busy), 0);

        // All equal
        fin  = '{8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A};
        fexp = fin;
        load_frame(fin, 1'b0, 8'd0);
        wait_sorted();
        drain(fexp, 9);

        // Already ascending input
        fin  = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
        fexp = '{8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
        load_frame(fin, 1'b0, 8'd0);
        wait_sorted();
        drain(fexp, 9);

        // Reset during SORT stage 3 discards the frame
        fin = '{8'd9, 8'd200, 8'd4, 8'd77, 8'd1, 8'd150, 8'd33, 8'd60};
        load_frame(fin, 1'b0, 8'd0);
        step();
        step();
        step();
        check("pre_rst_busy", int'(busy), 1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("midrst_in_ready", int'(in_ready), 1);
        check("midrst_busy", int'(busy), 0);
        check("midrst_out_valid", int'(out_valid), 0);
        fin  = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80};
        fexp = '{8'd80, 8'd70, 8'd60, 8'd50, 8'd40, 8'd30, 8'd20, 8'd10};
        load_frame(fin, 1'b0, 8'd0);
        wait_sorted();
        drain(fexp, 9);

        // Back-to-back frames with no idle cycles between them
        fin  = '{8'd200, 8'd1, 8'd150, 8'd3, 8'd100, 8'd5, 8'd50, 8'd7};
        fexp = '{8'd200, 8'd150, 8'd100, 8'd50, 8'd7, 8'd5, 8'd3, 8'd1};
        load_frame(fin, 1'b0, 8'd0);
        t_a = t_first;
        wait_sorted();
        drain(fexp, 9);
        fin  = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
        fexp = '{8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
        load_frame(fin, 1'b0, 8'd0);
        t_b = t_first;
        check("frame_period", t_b - t_a, 22);
        wait_sorted();
        drain(fexp, 9);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
